// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the data port and the shared memory
// command/response bus of mem_arbiter.
// The slave modport is the arbiter's own view.
// The master modport is the view of the surrounding pipeline plus memory.
interface mem_arbiter_if #(
   parameter int AW = 32
);

   // Instruction-fetch port
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [31:0]   if_rdata;
   logic          if_valid;
   logic          if_stall;

   // Data load/store port
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [31:0]   dm_wdata;
   logic [3:0]    dm_be;
   logic [31:0]   dm_rdata;
   logic          dm_valid;
   logic          dm_stall;

   // Shared single-port memory
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
   logic [31:0]   mem_rdata;
   logic          mem_ack;

   modport slave (
      input  if_req, if_addr,
      output if_rdata, if_valid, if_stall,
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      output dm_rdata, dm_valid, dm_stall,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_rdata, mem_ack
   );

   modport master (
      output if_req, if_addr,
      input  if_rdata, if_valid, if_stall,
      output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      input  dm_rdata, dm_valid, dm_stall,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch port
// and a data port.
//
// Priority rules:
//  - The data port normally wins, because it belongs to the older instruction
//    in the pipeline.
//  - Optional starvation guard, enabled by defining MEM_ARBITER_STARVE_GUARD_EN.
//    The guard counts data grants made while fetch is waiting. Once the count
//    reaches STARVE_MAX, the next arbitration goes to fetch.
//  - Without the macro, priority is strictly data-first.
//
// Registered outputs:
//  - The memory command is registered and held until mem_ack.
//  - Each completion produces a one-cycle valid pulse.
//  - The read-data outputs hold their last loaded value between transactions.
module mem_arbiter #(
   parameter int AW         = 32,
   parameter int STARVE_MAX = 4
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // Registered command and response state
   logic          mem_req_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [31:0]   mem_wdata_q;
   logic [3:0]    mem_be_q;
   logic          if_valid_q;
   logic          dm_valid_q;
   logic [31:0]   if_rdata_q;
   logic [31:0]   dm_rdata_q;

   // Next values for the above, produced by the output decoder
   logic          mem_req_n;
   logic          mem_we_n;
   logic [AW-1:0] mem_addr_n;
   logic [31:0]   mem_wdata_n;
   logic [3:0]    mem_be_n;
   logic          if_valid_n;
   logic          dm_valid_n;
   logic [31:0]   if_rdata_n;
   logic [31:0]   dm_rdata_n;

   // Arbitration result for the current IDLE cycle
   logic grant_dm;
   logic grant_if;

   // The guard counter is 8 bits at most, so a larger threshold could never be reached
   if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_starve_max_check
      $error("mem_arbiter: STARVE_MAX must lie in 1..255");
   end

`ifdef MEM_ARBITER_STARVE_GUARD_EN
   localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

   logic [CNT_W-1:0] starve_cnt;
   logic             fetch_due;

   assign fetch_due = (starve_cnt == CNT_W'(STARVE_MAX));

   // Count data grants made while fetch waits; any fetch grant clears the count
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant_if) begin
         starve_cnt <= '0;
      end else if (grant_dm && bus.if_req && !fetch_due) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end
`endif

   // Decide the winner in IDLE.
   // Raw request levels are used here, so a requester still high at the edge
   // closing its valid cycle is served again.
   // This lets a streaming data port issue back-to-back accesses.
   always_comb begin
      grant_dm = 1'b0;
      grant_if = 1'b0;
      if (state == IDLE) begin
`ifdef MEM_ARBITER_STARVE_GUARD_EN
         grant_dm = bus.dm_req && !(fetch_due && bus.if_req);
`else
         grant_dm = bus.dm_req;
`endif
         grant_if = bus.if_req && !grant_dm;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   // A BUSY state is left only on mem_ack; in IDLE an ack does nothing.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (grant_dm) begin
               state_next = DM_BUSY;
            end else if (grant_if) begin
               state_next = IF_BUSY;
            end
         end
         IF_BUSY: begin
            if (bus.mem_ack) begin
               state_next = IDLE;
            end
         end
         DM_BUSY: begin
            if (bus.mem_ack) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output decoder: load a command on a grant and retire it on mem_ack.
   // Anything not touched holds its value, so the command stays frozen while busy.
   always_comb begin
      mem_req_n   = mem_req_q;
      mem_we_n    = mem_we_q;
      mem_addr_n  = mem_addr_q;
      mem_wdata_n = mem_wdata_q;
      mem_be_n    = mem_be_q;
      if_valid_n  = 1'b0;
      dm_valid_n  = 1'b0;
      if_rdata_n  = if_rdata_q;
      dm_rdata_n  = dm_rdata_q;
      case (state)
         IDLE: begin
            if (grant_dm) begin
               mem_req_n   = 1'b1;
               mem_we_n    = bus.dm_we;
               mem_addr_n  = bus.dm_addr;
               mem_wdata_n = bus.dm_wdata;
               mem_be_n    = bus.dm_be;
            end else if (grant_if) begin
               mem_req_n   = 1'b1;
               mem_we_n    = 1'b0;
               mem_addr_n  = bus.if_addr;
               mem_be_n    = 4'hF;
            end
         end
         IF_BUSY: begin
            if (bus.mem_ack) begin
               mem_req_n  = 1'b0;
               if_valid_n = 1'b1;
               if_rdata_n = bus.mem_rdata;
            end
         end
         DM_BUSY: begin
            if (bus.mem_ack) begin
               mem_req_n  = 1'b0;
               dm_valid_n = 1'b1;
               if (!mem_we_q) begin
                  dm_rdata_n = bus.mem_rdata;
               end
            end
         end
         default: mem_req_n = 1'b0;
      endcase
   end

   // Command/response registers.
   // Reset abandons any access in flight and clears all of them.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= 4'h0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         mem_req_q   <= mem_req_n;
         mem_we_q    <= mem_we_n;
         mem_addr_q  <= mem_addr_n;
         mem_wdata_q <= mem_wdata_n;
         mem_be_q    <= mem_be_n;
         if_valid_q  <= if_valid_n;
         dm_valid_q  <= dm_valid_n;
         if_rdata_q  <= if_rdata_n;
         dm_rdata_q  <= dm_rdata_n;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.dm_valid  = dm_valid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;

   // A port stalls while it requests and its completion is not being signalled
   assign bus.if_stall  = bus.if_req & ~if_valid_q;
   assign bus.dm_stall  = bus.dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter.
// The reference model works per transaction: it picks a winner from the
// priority rule, predicts the issued command, and tracks the last loaded read data.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int AW         = 32;
   localparam int STARVE_MAX = 4;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
   localparam bit GUARD_ON = 1'b1;
`else
   localparam bit GUARD_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model state
   logic [31:0] exp_if_rdata;
   logic [31:0] exp_dm_rdata;
   int          model_cnt;

   mem_arbiter_if #(.AW(AW)) bus();

   mem_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Contents of the behavioural memory
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5AF00F;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.dm_req    = 1'b0;
      bus.dm_we     = 1'b0;
      bus.dm_addr   = '0;
      bus.dm_wdata  = '0;
      bus.dm_be     = 4'h0;
      bus.mem_rdata = '0;
      bus.mem_ack   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
      exp_if_rdata = '0;
      exp_dm_rdata = '0;
      model_cnt    = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({bus.mem_req, bus.mem_we, bus.if_valid, bus.dm_valid, bus.if_stall, bus.dm_stall} !== 6'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_flags: got req/we/ifv/dmv/ifs/dms=%b want 000000",
                  {bus.mem_req, bus.mem_we, bus.if_valid, bus.dm_valid, bus.if_stall, bus.dm_stall});
      end
      n_cmp++;
      if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_be !== 4'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_cmd: got addr=%h wdata=%h be=%h want 0/0/0",
                  bus.mem_addr, bus.mem_wdata, bus.mem_be);
      end
      n_cmp++;
      if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_rdata: got if=%h dm=%h want 0/0", bus.if_rdata, bus.dm_rdata);
      end
   endtask

   task automatic test_load();
      bus.dm_req  = 1'b1;
      bus.dm_we   = 1'b0;
      bus.dm_addr = 32'h40;
      tick();
      for (int c = 0; c < 3; c++) begin
         n_cmp++;
         if ({bus.mem_req, bus.mem_we, bus.dm_stall, bus.dm_valid} !== 4'b1010 ||
             bus.mem_addr !== 32'h40 || bus.dm_rdata !== exp_dm_rdata) begin
            n_fail++;
            $display("[TB] FAIL load_busy[%0d]: got req/we/stall/valid=%b addr=%h rdata=%h want 1010 40 %h",
                     c, {bus.mem_req, bus.mem_we, bus.dm_stall, bus.dm_valid}, bus.mem_addr,
                     bus.dm_rdata, exp_dm_rdata);
         end
         if (c == 2) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hDEADBEEF;
         end
         tick();
      end
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      exp_dm_rdata  = 32'hDEADBEEF;
      n_cmp++;
      if ({bus.dm_valid, bus.mem_req, bus.dm_stall, bus.if_valid} !== 4'b1000 ||
          bus.dm_rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("[TB] FAIL load_done: got valid/req/stall/ifv=%b rdata=%h want 1000 deadbeef",
                  {bus.dm_valid, bus.mem_req, bus.dm_stall, bus.if_valid}, bus.dm_rdata);
      end
      bus.dm_req = 1'b0;
      tick();
      n_cmp++;
      if (bus.dm_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.dm_rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("[TB] FAIL load_after: got valid=%b req=%b rdata=%h want 0 0 deadbeef",
                  bus.dm_valid, bus.mem_req, bus.dm_rdata);
      end
   endtask

   task automatic test_simultaneous();
      logic [31:0] fetch_word;
      fetch_word    = mem_word(32'h3000);
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h0000_3000;
      bus.dm_req    = 1'b1;
      bus.dm_we     = 1'b1;
      bus.dm_addr   = 32'h10;
      bus.dm_wdata  = 32'h12345678;
      bus.dm_be     = 4'b0011;
      tick();
      n_cmp++;
      if ({bus.mem_req, bus.mem_we, bus.if_stall, bus.dm_stall} !== 4'b1111 || bus.mem_addr !== 32'h10 ||
          bus.mem_wdata !== 32'h12345678 || bus.mem_be !== 4'b0011) begin
         n_fail++;
         $display("[TB] FAIL sim_store_cmd: got req/we/ifs/dms=%b addr=%h wdata=%h be=%b want 1111 10 12345678 0011",
                  {bus.mem_req, bus.mem_we, bus.if_stall, bus.dm_stall}, bus.mem_addr, bus.mem_wdata, bus.mem_be);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hBAD0BAD0;
      tick();
      bus.mem_ack   = 1'b0;
      n_cmp++;
      if ({bus.dm_valid, bus.if_valid, bus.mem_req, bus.if_stall} !== 4'b1001 || bus.dm_rdata !== exp_dm_rdata) begin
         n_fail++;
         $display("[TB] FAIL sim_store_done: got dmv/ifv/req/ifs=%b dm_rdata=%h want 1001 %h",
                  {bus.dm_valid, bus.if_valid, bus.mem_req, bus.if_stall}, bus.dm_rdata, exp_dm_rdata);
      end
      bus.dm_req = 1'b0;
      tick();
      n_cmp++;
      if ({bus.mem_req, bus.mem_we, bus.if_stall} !== 3'b101 || bus.mem_addr !== 32'h3000 || bus.mem_be !== 4'hF) begin
         n_fail++;
         $display("[TB] FAIL sim_fetch_cmd: got req/we/ifs=%b addr=%h be=%h want 101 3000 f",
                  {bus.mem_req, bus.mem_we, bus.if_stall}, bus.mem_addr, bus.mem_be);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = fetch_word;
      tick();
      bus.mem_ack   = 1'b0;
      exp_if_rdata  = fetch_word;
      n_cmp++;
      if ({bus.if_valid, bus.dm_valid, bus.mem_req, bus.if_stall} !== 4'b1000 || bus.if_rdata !== fetch_word) begin
         n_fail++;
         $display("[TB] FAIL sim_fetch_done: got ifv/dmv/req/ifs=%b if_rdata=%h want 1000 %h",
                  {bus.if_valid, bus.dm_valid, bus.mem_req, bus.if_stall}, bus.if_rdata, fetch_word);
      end
      bus.if_req = 1'b0;
      tick();
   endtask

   task automatic test_stray_ack();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hFFFF0000;
      tick();
      bus.mem_ack   = 1'b0;
      for (int c = 0; c < 2; c++) begin
         n_cmp++;
         if ({bus.mem_req, bus.mem_we, bus.if_valid, bus.dm_valid, bus.if_stall, bus.dm_stall} !== 6'b0 ||
             bus.mem_addr !== 32'h3000 || bus.mem_be !== 4'hF ||
             bus.if_rdata !== exp_if_rdata || bus.dm_rdata !== exp_dm_rdata) begin
            n_fail++;
            $display("[TB] FAIL stray_ack[%0d]: got flags=%b addr=%h be=%h ifr=%h dmr=%h want 000000 3000 f %h %h",
                     c, {bus.mem_req, bus.mem_we, bus.if_valid, bus.dm_valid, bus.if_stall, bus.dm_stall},
                     bus.mem_addr, bus.mem_be, bus.if_rdata, bus.dm_rdata, exp_if_rdata, exp_dm_rdata);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      bus.dm_req  = 1'b1;
      bus.dm_we   = 1'b0;
      bus.dm_addr = 32'h80;
      tick();
      n_cmp++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80) begin
         n_fail++;
         $display("[TB] FAIL rstmid_grant: got req=%b addr=%h want 1 80", bus.mem_req, bus.mem_addr);
      end
      rst        = 1'b1;
      bus.dm_req = 1'b0;
      tick();
      rst          = 1'b0;
      exp_if_rdata = '0;
      exp_dm_rdata = '0;
      model_cnt    = 0;
      n_cmp++;
      if ({bus.mem_req, bus.dm_valid} !== 2'b00 || bus.mem_addr !== 32'h0 || bus.mem_be !== 4'h0 ||
          bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL rstmid_cleared: got req/dmv=%b addr=%h be=%h ifr=%h dmr=%h want 00 0 0 0 0",
                  {bus.mem_req, bus.dm_valid}, bus.mem_addr, bus.mem_be, bus.if_rdata, bus.dm_rdata);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h11112222;
      tick();
      bus.mem_ack   = 1'b0;
      n_cmp++;
      if ({bus.mem_req, bus.dm_valid, bus.if_valid} !== 3'b000 || bus.dm_rdata !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL rstmid_late_ack: got req/dmv/ifv=%b dmr=%h want 000 0",
                  {bus.mem_req, bus.dm_valid, bus.if_valid}, bus.dm_rdata);
      end
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h500;
      tick();
      n_cmp++;
      if ({bus.mem_req, bus.mem_we} !== 2'b10 || bus.mem_addr !== 32'h500 || bus.mem_be !== 4'hF) begin
         n_fail++;
         $display("[TB] FAIL rstmid_idle_regrant: got req/we=%b addr=%h be=%h want 10 500 f",
                  {bus.mem_req, bus.mem_we}, bus.mem_addr, bus.mem_be);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = mem_word(32'h500);
      tick();
      bus.mem_ack   = 1'b0;
      exp_if_rdata  = mem_word(32'h500);
      n_cmp++;
      if (bus.if_valid !== 1'b1 || bus.if_rdata !== exp_if_rdata) begin
         n_fail++;
         $display("[TB] FAIL rstmid_fetch: got ifv=%b ifr=%h want 1 %h", bus.if_valid, bus.if_rdata, exp_if_rdata);
      end
      bus.if_req = 1'b0;
      tick();
   endtask

   // Both ports request continuously; memory acks in the first cycle of each command
   task automatic test_starve();
      int          grants;
      logic        want_fetch;
      logic [31:0] want_addr;
      do_reset();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h100;
      bus.dm_req  = 1'b1;
      bus.dm_we   = 1'b0;
      bus.dm_addr = 32'h200;
      grants      = 0;
      for (int c = 0; c < 60 && grants < 10; c++) begin
         tick();
         if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
         end else if (bus.mem_req === 1'b1) begin
            want_fetch = GUARD_ON && (model_cnt == STARVE_MAX);
            want_addr  = want_fetch ? 32'h100 : 32'h200;
            model_cnt  = want_fetch ? 0 : model_cnt + 1;
            n_cmp++;
            if (bus.mem_addr !== want_addr || bus.if_stall !== 1'b1) begin
               n_fail++;
               $display("[TB] FAIL starve_grant[%0d]: got addr=%h if_stall=%b want %h 1",
                        grants, bus.mem_addr, bus.if_stall, want_addr);
            end
            grants++;
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_word(bus.mem_addr);
         end
      end
      n_cmp++;
      if (grants != 10) begin
         n_fail++;
         $display("[TB] FAIL starve_grant_count: got %0d want 10", grants);
      end
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
      tick();
      bus.mem_ack = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_random();
      logic        p_if, p_dm, win_dm;
      logic        w_we;
      logic [31:0] w_addr, w_wdata, word;
      logic [3:0]  w_be;
      int          lat;
      do_reset();
      p_if = 1'b0;
      p_dm = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if (!p_if && !p_dm) begin
            case ($urandom_range(2, 0))
               0:       p_if = 1'b1;
               1:       p_dm = 1'b1;
               default: begin p_if = 1'b1; p_dm = 1'b1; end
            endcase
            if (p_if) begin
               bus.if_req  = 1'b1;
               bus.if_addr = $urandom & 32'h0000_FFFC;
            end
            if (p_dm) begin
               bus.dm_req   = 1'b1;
               bus.dm_we    = 1'($urandom_range(1, 0));
               bus.dm_addr  = $urandom & 32'h0000_FFFC;
               bus.dm_wdata = $urandom;
               bus.dm_be    = 4'($urandom_range(15, 1));
            end
         end
         win_dm = p_dm && !(GUARD_ON && p_if && model_cnt == STARVE_MAX);
         if (win_dm) begin
            w_we = bus.dm_we; w_addr = bus.dm_addr; w_wdata = bus.dm_wdata; w_be = bus.dm_be;
            model_cnt = p_if ? model_cnt + 1 : model_cnt;
         end else begin
            w_we = 1'b0; w_addr = bus.if_addr; w_wdata = '0; w_be = 4'hF;
            model_cnt = 0;
         end
         word = mem_word(w_addr);
         lat  = $urandom_range(4, 1);
         tick();
         for (int k = 1; k <= lat; k++) begin
            n_cmp++;
            if (bus.mem_req !== 1'b1 || bus.mem_we !== w_we || bus.mem_addr !== w_addr || bus.mem_be !== w_be ||
                (w_we && bus.mem_wdata !== w_wdata) || bus.if_stall !== p_if || bus.dm_stall !== p_dm) begin
               n_fail++;
               $display("[TB] FAIL rand_cmd[%0d.%0d]: got req=%b we=%b addr=%h be=%h wd=%h ifs=%b dms=%b want 1 %b %h %h %h %b %b",
                        t, k, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.if_stall,
                        bus.dm_stall, w_we, w_addr, w_be, w_wdata, p_if, p_dm);
            end
            if (k == lat) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = word;
            end
            tick();
         end
         bus.mem_ack = 1'b0;
         if (win_dm && !w_we) exp_dm_rdata = word;
         if (!win_dm) exp_if_rdata = word;
         n_cmp++;
         if (bus.dm_valid !== win_dm || bus.if_valid !== !win_dm || bus.mem_req !== 1'b0 ||
             bus.if_rdata !== exp_if_rdata || bus.dm_rdata !== exp_dm_rdata ||
             bus.if_stall !== (p_if && win_dm) || bus.dm_stall !== (p_dm && !win_dm)) begin
            n_fail++;
            $display("[TB] FAIL rand_done[%0d]: got dmv=%b ifv=%b req=%b ifr=%h dmr=%h ifs=%b dms=%b want %b %b 0 %h %h %b %b",
                     t, bus.dm_valid, bus.if_valid, bus.mem_req, bus.if_rdata, bus.dm_rdata, bus.if_stall,
                     bus.dm_stall, win_dm, !win_dm, exp_if_rdata, exp_dm_rdata, p_if && win_dm, p_dm && !win_dm);
         end
         if (win_dm) begin
            p_dm = 1'b0; bus.dm_req = 1'b0;
         end else begin
            p_if = 1'b0; bus.if_req = 1'b0;
         end
         if (!p_if && $urandom_range(1, 0) == 1) begin
            p_if = 1'b1; bus.if_req = 1'b1; bus.if_addr = $urandom & 32'h0000_FFFC;
         end
         if (!p_dm && $urandom_range(1, 0) == 1) begin
            p_dm = 1'b1; bus.dm_req = 1'b1; bus.dm_we = 1'($urandom_range(1, 0));
            bus.dm_addr = $urandom & 32'h0000_FFFC; bus.dm_wdata = $urandom;
            bus.dm_be = 4'($urandom_range(15, 1));
         end
      end
      clear_inputs();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      $display("[TB] mem_arbiter bench start, starvation guard %0s", GUARD_ON ? "on" : "off");
      test_reset();
      test_load();
      test_simultaneous();
      test_stray_ack();
      test_reset_mid();
      test_starve();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
